// File: rtl/execution_memory_skid_register.sv
// Execution-to-memory pipeline register with a valid/ready handshake and a one-entry skid buffer.
// ready_o depends only on registered state, so downstream stalls never reach the ALU combinationally.
module execution_memory_skid_register #(
   parameter int WORD       = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int SRC_W      = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  flush_i,
   input  logic                  is_valid_i,
   output logic                  ready_o,
   input  logic                  mem_write_en_i,
   input  logic                  reg_file_write_en_i,
   input  logic [SRC_W-1:0]      reg_file_data_source_i,
   input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
   input  logic [WORD-1:0]       alu_result_i,
   input  logic [WORD-1:0]       reg_2_data_i,
   output logic                  is_valid_o,
   input  logic                  ready_i,
   output logic                  mem_write_en_o,
   output logic                  reg_file_write_en_o,
   output logic [SRC_W-1:0]      reg_file_data_source_o,
   output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
   output logic [WORD-1:0]       alu_result_o,
   output logic [WORD-1:0]       reg_2_data_o,
   output logic [1:0]            occupancy_o
);

   localparam int PW = 2 + SRC_W + ADDR_WIDTH + 2 * WORD;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   logic [1:0]    state_reg, state_next;
   logic [PW-1:0] main_reg, main_next;
   logic [PW-1:0] skid_reg, skid_next;
   logic [PW-1:0] in_payload;
   logic          acc, pop;
   logic          mem_write_en_held, reg_file_write_en_held;

   assign in_payload = {mem_write_en_i, reg_file_write_en_i, reg_file_data_source_i,
                        reg_dest_addr_i, alu_result_i, reg_2_data_i};

   assign ready_o     = (state_reg != TWO);
   assign is_valid_o  = (state_reg != EMPTY);
   assign occupancy_o = state_reg;

   assign acc = is_valid_i & ready_o;
   assign pop = is_valid_o & ready_i;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      if (flush_i) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (acc) begin
                  main_next  = in_payload;
                  state_next = ONE;
               end
            end
            ONE: begin
               if (acc && pop) begin
                  main_next = in_payload;
               end else if (acc) begin
                  skid_next  = in_payload;
                  state_next = TWO;
               end else if (pop) begin
                  state_next = EMPTY;
               end
            end
            TWO: begin
               // ready_o is low here, so only a pop can move the entries
               if (pop) begin
                  main_next  = skid_reg;
                  state_next = ONE;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg <= EMPTY;
         main_reg  <= '0;
         skid_reg  <= '0;
      end else begin
         state_reg <= state_next;
         main_reg  <= main_next;
         skid_reg  <= skid_next;
      end
   end

   assign {mem_write_en_held, reg_file_write_en_held, reg_file_data_source_o,
           reg_dest_addr_o, alu_result_o, reg_2_data_o} = main_reg;

   // Enables are masked so a bubble can never write memory or the register file
   assign mem_write_en_o      = mem_write_en_held & is_valid_o;
   assign reg_file_write_en_o = reg_file_write_en_held & is_valid_o;

endmodule
